// File: rtl/window3x3_seq.sv
// -----------------------------------------------------------------------------
// window3x3_seq
//
// Raster sequencer for a 3x3 sliding-window datapath (two W-long line buffers
// and a 3x3 shift register). That datapath shifts on every clock with no
// enable. This block therefore follows the frame position in lockstep with it.
// It produces sideband flags that are time-aligned with the window registers,
// and it flags protocol errors on the input stream.
//
// Ports:
//   clk        system clock; the datapath samples its pixel on the same edge
//   rst_n      asynchronous active-low reset
//   in_valid   pixel presented to the window this cycle
//   in_sof     qualifies in_valid; marks pixel index 0 of a frame
//   busy       frame in progress (PRIME or ACTIVE)
//   win_valid  window registers hold a full 3x3 neighbourhood this cycle
//   win_col    centre column of the current window (valid with win_valid)
//   win_row    centre row of the current window (valid with win_valid)
//   win_first  current window is centre (1,1)
//   win_last   current window is centre (H-2,W-2)
//   frame_done one-cycle pulse, coincident with win_last
//   err_gap    one-cycle pulse: in_valid dropped mid-frame
//   err_sof    one-cycle pulse: in_sof seen mid-frame
// -----------------------------------------------------------------------------
module window3x3_seq #(
    parameter int W  = 3124,
    parameter int H  = 3124,
    parameter int CW = $clog2(W),
    parameter int RW = $clog2(H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    output logic          busy,
    output logic          win_valid,
    output logic [CW-1:0] win_col,
    output logic [RW-1:0] win_row,
    output logic          win_first,
    output logic          win_last,
    output logic          frame_done,
    output logic          err_gap,
    output logic          err_sof
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Position (row, column) of the pixel that is held in p22. The window
    // centre is exactly one row up and one column left of that pixel.
    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    logic          r_busy;
    logic          r_win_valid;
    logic [CW-1:0] r_win_col;
    logic [RW-1:0] r_win_row;
    logic          r_win_first;
    logic          r_win_last;
    logic          r_frame_done;
    logic          r_err_gap;
    logic          r_err_sof;

    state_t        w_state_next;
    logic [CW-1:0] w_col_next;
    logic [RW-1:0] w_row_next;
    logic          w_win_valid_next;
    logic [CW-1:0] w_win_col_next;
    logic [RW-1:0] w_win_row_next;
    logic          w_win_first_next;
    logic          w_win_last_next;
    logic          w_frame_done_next;
    logic          w_err_gap_next;
    logic          w_err_sof_next;

    // Pixel position after a normal increment, and the window flags at that position.
    logic [CW-1:0] w_inc_col;
    logic [RW-1:0] w_inc_row;
    logic          w_inc_full;
    logic          w_inc_first;
    logic          w_inc_last;

    always_comb begin
        w_inc_col = r_col + CW'(1);
        w_inc_row = r_row;
        if (r_col == COL_LAST) begin
            w_inc_col = '0;
            w_inc_row = r_row + RW'(1);
        end
        // The centre is (row-1, col-1) of p22. Consider a p22 column of 0 or 1:
        // the window then straddles a line wrap. Consider a p22 row below 2:
        // the window then straddles the top of the frame. The bottom edge needs
        // no test, because the frame ends at the last pixel.
        w_inc_full  = (w_inc_col >= COL_TWO) && (w_inc_row >= ROW_TWO);
        w_inc_first = (w_inc_col == COL_TWO) && (w_inc_row == ROW_TWO);
        w_inc_last  = (w_inc_col == COL_LAST) && (w_inc_row == ROW_LAST);
    end

    always_comb begin
        w_state_next      = r_state;
        w_col_next        = r_col;
        w_row_next        = r_row;
        w_win_valid_next  = 1'b0;
        w_win_col_next    = '0;
        w_win_row_next    = '0;
        w_win_first_next  = 1'b0;
        w_win_last_next   = 1'b0;
        w_frame_done_next = 1'b0;
        w_err_gap_next    = 1'b0;
        w_err_sof_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (in_valid && in_sof) begin
                    w_state_next = S_PRIME;
                    w_col_next   = '0;
                    w_row_next   = '0;
                end
            end
            default: begin
                if (!in_valid) begin
                    // The datapath keeps shifting, so the window contents are
                    // now corrupt. Abort the frame.
                    w_err_gap_next = 1'b1;
                    w_state_next   = S_IDLE;
                    w_col_next     = '0;
                    w_row_next     = '0;
                end else if (in_sof) begin
                    // A restart wins over a normal increment. This also holds on the final pixel.
                    w_err_sof_next = 1'b1;
                    w_state_next   = S_PRIME;
                    w_col_next     = '0;
                    w_row_next     = '0;
                end else begin
                    w_col_next       = w_inc_col;
                    w_row_next       = w_inc_row;
                    w_win_valid_next = w_inc_full;
                    w_win_first_next = w_inc_first;
                    if (w_inc_full) begin
                        w_win_col_next = w_inc_col - CW'(1);
                        w_win_row_next = w_inc_row - RW'(1);
                    end
                    if (w_inc_last) begin
                        w_win_last_next   = 1'b1;
                        w_frame_done_next = 1'b1;
                        w_state_next      = S_IDLE;
                        w_col_next        = '0;
                        w_row_next        = '0;
                    end else if ((r_state == S_PRIME) && w_inc_first) begin
                        w_state_next = S_ACTIVE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_busy       <= 1'b0;
            r_win_valid  <= 1'b0;
            r_win_col    <= '0;
            r_win_row    <= '0;
            r_win_first  <= 1'b0;
            r_win_last   <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_gap    <= 1'b0;
            r_err_sof    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_col        <= w_col_next;
            r_row        <= w_row_next;
            r_busy       <= (w_state_next != S_IDLE);
            r_win_valid  <= w_win_valid_next;
            r_win_col    <= w_win_col_next;
            r_win_row    <= w_win_row_next;
            r_win_first  <= w_win_first_next;
            r_win_last   <= w_win_last_next;
            r_frame_done <= w_frame_done_next;
            r_err_gap    <= w_err_gap_next;
            r_err_sof    <= w_err_sof_next;
        end
    end

    assign busy       = r_busy;
    assign win_valid  = r_win_valid;
    assign win_col    = r_win_col;
    assign win_row    = r_win_row;
    assign win_first  = r_win_first;
    assign win_last   = r_win_last;
    assign frame_done = r_frame_done;
    assign err_gap    = r_err_gap;
    assign err_sof    = r_err_sof;

endmodule

// File: tb/tb_window3x3_seq.sv
// -----------------------------------------------------------------------------
// tb_window3x3_seq
//
// Bench for window3x3_seq with an 8x6 frame. Each vector record holds the
// input strobes for one cycle and the expected outputs for the cycle after the
// edge. An expected value of -1 means "don't care". The expected window
// position comes from the centre-index formula m = k - W - 1. Asynchronous
// reset is tested in hand-written sequences.
// -----------------------------------------------------------------------------
module tb_window3x3_seq;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_sof;
    logic          busy;
    logic          win_valid;
    logic [CW-1:0] win_col;
    logic [RW-1:0] win_row;
    logic          win_first;
    logic          win_last;
    logic          frame_done;
    logic          err_gap;
    logic          err_sof;

    window3x3_seq #(.W(W), .H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .busy       (busy),
        .win_valid  (win_valid),
        .win_col    (win_col),
        .win_row    (win_row),
        .win_first  (win_first),
        .win_last   (win_last),
        .frame_done (frame_done),
        .err_gap    (err_gap),
        .err_sof    (err_sof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic v;
        logic s;
        int   seg;
        int   exp_valid;
        int   exp_col;
        int   exp_row;
        int   exp_first;
        int   exp_last;
        int   exp_done;
        int   exp_gap;
        int   exp_esof;
        int   exp_busy;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   win_cnt[9];
    int   done_cnt[9];
    int   done_cyc[$];

    task automatic chk(input string nm, input int act, input int expv);
        if (expv >= 0) begin
            checks++;
            if (act != expv) begin
                errors++;
                $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},       int'(busy),       0);
        chk({tag, "_win_valid"},  int'(win_valid),  0);
        chk({tag, "_win_col"},    int'(win_col),    0);
        chk({tag, "_win_row"},    int'(win_row),    0);
        chk({tag, "_win_first"},  int'(win_first),  0);
        chk({tag, "_win_last"},   int'(win_last),   0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_err_gap"},    int'(err_gap),    0);
        chk({tag, "_err_sof"},    int'(err_sof),    0);
        $display("reset check %s busy=%b valid=%b done=%b gap=%b esof=%b",
                 tag, busy, win_valid, frame_done, err_gap, err_sof);
    endtask

    // Accepted pixel with frame index k. The expected flags come from the centre index m = k - W - 1.
    function automatic void push_pixel(input int k, input logic s, input int seg);
        vec_t t;
        int   m;
        int   r;
        int   c;
        t.v = 1'b1; t.s = s; t.seg = seg;
        t.exp_valid = 0; t.exp_col = -1; t.exp_row = -1; t.exp_first = 0;
        m = k - W - 1;
        if (m >= 0) begin
            r = m / W;
            c = m % W;
            if (r >= 1 && r <= H - 2 && c >= 1 && c <= W - 2) begin
                t.exp_valid = 1; t.exp_col = c; t.exp_row = r;
            end
            t.exp_first = (r == 1 && c == 1) ? 1 : 0;
        end
        t.exp_last = (k == H * W - 1) ? 1 : 0;
        t.exp_done = t.exp_last;
        t.exp_gap  = 0;
        t.exp_esof = 0;
        t.exp_busy = (k == H * W - 1) ? -1 : 1;
        vq.push_back(t);
    endfunction

    function automatic void push_frame(input int k0, input int k1, input logic sof_first, input int seg);
        for (int k = k0; k <= k1; k++)
            push_pixel(k, (k == k0) ? sof_first : 1'b0, seg);
    endfunction

    function automatic void push_idle(input logic v, input logic s, input int seg);
        vec_t t;
        t.v = v; t.s = s; t.seg = seg;
        t.exp_valid = 0; t.exp_col = -1; t.exp_row = -1; t.exp_first = 0;
        t.exp_last = 0; t.exp_done = 0; t.exp_gap = 0; t.exp_esof = 0; t.exp_busy = 0;
        vq.push_back(t);
    endfunction

    function automatic void push_gap(input int seg);
        push_idle(1'b0, 1'b0, seg);
        vq[vq.size() - 1].exp_gap = 1;
    endfunction

    function automatic void push_sof_restart(input int seg);
        push_pixel(0, 1'b1, seg);
        vq[vq.size() - 1].exp_esof = 1;
    endfunction

    task automatic run_vecs();
        foreach (vq[i]) begin
            in_valid = vq[i].v;
            in_sof   = vq[i].s;
            @(posedge clk);
            #1;
            cyc++;
            chk("win_valid",  int'(win_valid),  vq[i].exp_valid);
            chk("win_col",    int'(win_col),    vq[i].exp_col);
            chk("win_row",    int'(win_row),    vq[i].exp_row);
            chk("win_first",  int'(win_first),  vq[i].exp_first);
            chk("win_last",   int'(win_last),   vq[i].exp_last);
            chk("frame_done", int'(frame_done), vq[i].exp_done);
            chk("err_gap",    int'(err_gap),    vq[i].exp_gap);
            chk("err_sof",    int'(err_sof),    vq[i].exp_esof);
            chk("busy",       int'(busy),       vq[i].exp_busy);
            if (win_valid) win_cnt[vq[i].seg]++;
            if (frame_done) begin
                done_cnt[vq[i].seg]++;
                if (vq[i].seg == 5) done_cyc.push_back(cyc);
            end
            $display("cyc %0d seg %0d v=%b s=%b -> busy=%b valid=%b col=%0d row=%0d first=%b last=%b done=%b gap=%b esof=%b",
                     cyc, vq[i].seg, vq[i].v, vq[i].s, busy, win_valid, win_col, win_row,
                     win_first, win_last, frame_done, err_gap, err_sof);
        end
        vq.delete();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 9; i++) begin
            win_cnt[i]  = 0;
            done_cnt[i] = 0;
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        chk_all_zero("in_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all_zero("after_release");

        // Idle: a pixel without sof, or sof without valid, must be ignored.
        push_idle(1'b0, 1'b0, 0);
        push_idle(1'b1, 1'b0, 0);
        push_idle(1'b0, 1'b1, 0);
        run_vecs();

        // Single full frame, then idle.
        push_frame(0, H * W - 1, 1'b1, 1);
        push_idle(1'b0, 1'b0, 1);
        run_vecs();
        chk("frame1_windows", win_cnt[1], 24);
        chk("frame1_done",    done_cnt[1], 1);

        // in_valid drops at pixel 20. Later pixels without sof are ignored.
        push_frame(0, 19, 1'b1, 2);
        push_gap(2);
        for (int i = 0; i < 5; i++) push_idle(1'b1, 1'b0, 2);
        run_vecs();
        chk("gap_windows", win_cnt[2], 2);
        chk("gap_done",    done_cnt[2], 0);

        // in_sof is reasserted at pixel 30. The full frame that follows must still complete.
        push_frame(0, 29, 1'b1, 3);
        push_sof_restart(4);
        push_frame(1, H * W - 1, 1'b0, 4);
        push_idle(1'b0, 1'b0, 4);
        run_vecs();
        chk("sof_pre_windows",   win_cnt[3], 10);
        chk("sof_pre_done",      done_cnt[3], 0);
        chk("sof_after_windows", win_cnt[4], 24);
        chk("sof_after_done",    done_cnt[4], 1);

        // Two frames back to back with no idle cycle between them.
        push_frame(0, H * W - 1, 1'b1, 5);
        push_frame(0, H * W - 1, 1'b1, 5);
        push_idle(1'b0, 1'b0, 5);
        run_vecs();
        chk("b2b_windows", win_cnt[5], 48);
        chk("b2b_done_pulses", done_cyc.size(), 2);
        if (done_cyc.size() == 2)
            chk("b2b_done_spacing", done_cyc[1] - done_cyc[0], 48);

        // in_sof arrives on the final pixel: this is a restart, not a frame completion.
        push_frame(0, H * W - 2, 1'b1, 6);
        push_sof_restart(6);
        push_gap(6);
        run_vecs();
        chk("sof_last_windows", win_cnt[6], 23);
        chk("sof_last_done",    done_cnt[6], 0);

        // Reset pulsed mid-frame at pixel 25.
        push_frame(0, 24, 1'b1, 7);
        run_vecs();
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        chk_all_zero("reset_held");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk_all_zero("reset_release");
        chk("reset_windows", win_cnt[7], 6);
        chk("reset_done",    done_cnt[7], 0);

        push_frame(0, H * W - 1, 1'b1, 8);
        push_idle(1'b0, 1'b0, 8);
        run_vecs();
        chk("post_reset_windows", win_cnt[8], 24);
        chk("post_reset_done",    done_cnt[8], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
